// File: rtl/sys_out_rd.sv
// -----------------------------------------------------------------------------
// sys_out_rd
//   Read-side sequencer for the sys_out dual-port RAM. On start it reads the
//   RAM back in linear order, GAMMA frames of M words each. Words stream out
//   over a valid/ready interface, and a 2-entry skid FIFO absorbs backpressure.
//   Read issue is credit-limited, so the FIFO cannot overflow.
//
//   Optional feature macro: SYS_OUT_RD_PARITY_EN
//     When defined, out_par is added. It is the even parity of
//     {out_last, out_data} and is stored with each FIFO entry.
//
// Ports:
//   sys_clk   in   clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   start     in   single-cycle pass request, honoured only when idle
//   rd_en     out  DPR read strobe
//   rd_addr   out  DPR read address (FEATURE_BITS)
//   rd_data   in   DPR read data, valid one cycle after rd_en (DATA_W)
//   out_valid out  out_data/out_last valid
//   out_ready in   downstream accept
//   out_data  out  word at FIFO head (DATA_W)
//   out_last  out  final word of a frame
//   out_par   out  parity of {out_last,out_data} (SYS_OUT_RD_PARITY_EN only)
//   busy      out  pass in progress
//   done      out  one-cycle pulse after the final word of the pass
// -----------------------------------------------------------------------------
module sys_out_rd #(
  parameter int FEATURE_BITS = 4,
  parameter int M            = 9,
  parameter int GAMMA        = 3,
  parameter int DATA_W       = 16
) (
  input  logic                    sys_clk,
  input  logic                    reset_n,
  input  logic                    start,
  output logic                    rd_en,
  output logic [FEATURE_BITS-1:0] rd_addr,
  input  logic [DATA_W-1:0]       rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last,
`ifdef SYS_OUT_RD_PARITY_EN
  output logic                    out_par,
`endif
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [FEATURE_BITS-1:0] M_LAST = FEATURE_BITS'(M - 1);
  localparam logic [FEATURE_BITS-1:0] G_LAST = FEATURE_BITS'(GAMMA - 1);

  // A FIFO entry is {[par,] last, data}; the head entry drives the outputs.
`ifdef SYS_OUT_RD_PARITY_EN
  localparam int ENT_W = DATA_W + 2;

  function automatic logic even_par(input logic last, input logic [DATA_W-1:0] data);
    return ^{last, data};
  endfunction
`else
  localparam int ENT_W = DATA_W + 1;
`endif

  state_t                  state_r;
  state_t                  state_s;
  logic [FEATURE_BITS-1:0] m_it_r;
  logic [FEATURE_BITS-1:0] g_it_r;
  logic                    inflight_r;
  logic                    last_tag_r;
  logic [1:0]              count_r;
  logic [1:0]              count_s;
  logic [ENT_W-1:0]        head_r;
  logic [ENT_W-1:0]        head_s;
  logic [ENT_W-1:0]        tail_r;
  logic [ENT_W-1:0]        tail_s;
  logic [ENT_W-1:0]        new_ent_s;
  logic                    out_valid_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    rd_en_s;
  logic                    start_ok_s;
  logic                    finish_s;
  logic                    pop_s;
  logic [2:0]              credit_s;

  assign pop_s = out_valid_r & out_ready;

  // Occupancy the FIFO will have once the in-flight word lands and this
  // cycle's pop leaves; a new read is allowed only while this is below 2.
  assign credit_s = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};

`ifdef SYS_OUT_RD_PARITY_EN
  assign new_ent_s = {even_par(last_tag_r, rd_data), last_tag_r, rd_data};
`else
  assign new_ent_s = {last_tag_r, rd_data};
`endif

  // Next-state, read issue and pass start/finish decode.
  always_comb begin
    state_s    = state_r;
    rd_en_s    = 1'b0;
    start_ok_s = 1'b0;
    finish_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // A start coinciding with the done pulse is dropped.
        if (start && !done_r) begin
          start_ok_s = 1'b1;
          state_s    = ST_READ;
        end else begin
          state_s    = ST_IDLE;
        end
      end
      ST_READ: begin
        if (credit_s < 3'd2) begin
          rd_en_s = 1'b1;
          if ((m_it_r == M_LAST) && (g_it_r == G_LAST)) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_READ;
          end
        end else begin
          state_s = ST_READ;
        end
      end
      ST_DRAIN: begin
        // Nothing in flight and the FIFO empties with this cycle's pop.
        if (!inflight_r && (credit_s == 3'd0)) begin
          finish_s = 1'b1;
          state_s  = ST_IDLE;
        end else begin
          state_s  = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Skid FIFO next values: push from the in-flight read, pop on handshake.
  always_comb begin
    count_s = count_r;
    head_s  = head_r;
    tail_s  = tail_r;
    case ({inflight_r, pop_s})
      2'b10: begin
        count_s = count_r + 2'd1;
        if (count_r == 2'd0) begin
          head_s = new_ent_s;
        end else begin
          tail_s = new_ent_s;
        end
      end
      2'b01: begin
        count_s = count_r - 2'd1;
        if (count_r == 2'd2) begin
          head_s = tail_r;
        end else begin
          head_s = head_r;
        end
      end
      2'b11: begin
        count_s = count_r;
        if (count_r == 2'd1) begin
          head_s = new_ent_s;
        end else begin
          head_s = tail_r;
          tail_s = new_ent_s;
        end
      end
      default: begin
        count_s = count_r;
      end
    endcase
  end

  // State, status and in-flight tracking registers.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      inflight_r <= 1'b0;
      last_tag_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      done_r     <= finish_s;
      inflight_r <= rd_en_s;
      last_tag_r <= rd_en_s & (m_it_r == M_LAST);
      if (start_ok_s) begin
        busy_r <= 1'b1;
      end else if (finish_s) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= busy_r;
      end
    end
  end

  // Word (m) and frame (g) counters, advanced once per issued read.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      m_it_r <= {FEATURE_BITS{1'b0}};
      g_it_r <= {FEATURE_BITS{1'b0}};
    end else if (start_ok_s) begin
      m_it_r <= {FEATURE_BITS{1'b0}};
      g_it_r <= {FEATURE_BITS{1'b0}};
    end else if (rd_en_s) begin
      if (m_it_r == M_LAST) begin
        m_it_r <= {FEATURE_BITS{1'b0}};
        if (g_it_r == G_LAST) begin
          g_it_r <= {FEATURE_BITS{1'b0}};
        end else begin
          g_it_r <= g_it_r + FEATURE_BITS'(1);
        end
      end else begin
        m_it_r <= m_it_r + FEATURE_BITS'(1);
      end
    end else begin
      m_it_r <= m_it_r;
      g_it_r <= g_it_r;
    end
  end

  // Skid FIFO storage; the head register feeds the outputs directly.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r     <= 2'd0;
      head_r      <= {ENT_W{1'b0}};
      tail_r      <= {ENT_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      count_r     <= count_s;
      head_r      <= head_s;
      tail_r      <= tail_s;
      out_valid_r <= (count_s != 2'd0);
    end
  end

  assign rd_en     = rd_en_s;
  assign rd_addr   = m_it_r;
  assign out_valid = out_valid_r;
  assign out_data  = head_r[DATA_W-1:0];
  assign out_last  = head_r[DATA_W];
`ifdef SYS_OUT_RD_PARITY_EN
  assign out_par   = head_r[DATA_W+1];
`endif
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_sys_out_rd.sv
// -----------------------------------------------------------------------------
// tb_sys_out_rd
//   Directed self-checking bench for sys_out_rd (M=9, GAMMA=3, RAM[a]=0x100+a).
//   Scenarios: free run with exact timing, start in the done cycle, periodic
//   backpressure, a 5-cycle stall on the frame-final word, start while busy,
//   reset mid-pass, and (with SYS_OUT_RD_PARITY_EN) parity values.
// -----------------------------------------------------------------------------
module tb_sys_out_rd;

  localparam int FB = 4;
  localparam int M  = 9;
  localparam int G  = 3;
  localparam int DW = 16;
  localparam int NW = M * G;

  logic          sys_clk   = 1'b0;
  logic          reset_n   = 1'b0;
  logic          start     = 1'b0;
  logic          out_ready = 1'b0;
  logic          rd_en;
  logic [FB-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;
`ifdef SYS_OUT_RD_PARITY_EN
  logic          out_par;
`endif

  sys_out_rd #(.FEATURE_BITS(FB), .M(M), .GAMMA(G), .DATA_W(DW)) dut (
    .sys_clk   (sys_clk),
    .reset_n   (reset_n),
    .start     (start),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
`ifdef SYS_OUT_RD_PARITY_EN
    .out_par   (out_par),
`endif
    .busy      (busy),
    .done      (done)
  );

  always #5 sys_clk = ~sys_clk;

  // RAM model: one-cycle read latency
  logic [DW-1:0] ram [0:15];
  always @(posedge sys_clk) begin
    if (rd_en) rd_data <= ram[rd_addr];
  end

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Handshake log and per-cycle protocol checks
  logic [DW-1:0] q_data [$];
  bit            q_last [$];
  bit            q_par  [$];
  int            q_cyc  [$];
  int            pass_s = 0;
  int            occ    = 0;
  logic          prev_rd   = 1'b0;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  wire           hs = out_valid & out_ready;

  always @(negedge sys_clk) begin
    if (!reset_n) begin
      occ       <= 0;
      prev_rd   <= 1'b0;
      prev_hold <= 1'b0;
    end else begin
      if (rd_en) chk("credit", 32'((occ + int'(prev_rd) - int'(hs)) < 2), 32'd1);
      chk("valid_occ", 32'(out_valid), 32'(occ != 0));
      chk("no_ovf", 32'(occ <= 2), 32'd1);
      if (prev_hold) begin
        chk("hold_data", 32'(out_data), 32'(prev_data));
        chk("hold_last", 32'(out_last), 32'(prev_last));
      end
`ifdef SYS_OUT_RD_PARITY_EN
      if (out_valid) chk("par_live", 32'(out_par), 32'(^{out_last, out_data}));
`endif
      if (hs) begin
        q_data.push_back(out_data);
        q_last.push_back(out_last);
        q_cyc.push_back(cyc - pass_s);
`ifdef SYS_OUT_RD_PARITY_EN
        q_par.push_back(out_par);
`else
        q_par.push_back(1'b0);
`endif
      end
      occ       <= occ + int'(prev_rd) - int'(hs);
      prev_rd   <= rd_en;
      prev_hold <= out_valid & ~out_ready;
      prev_data <= out_data;
      prev_last <= out_last;
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_en"},     32'(rd_en),     32'd0);
    chk({tag, "_rd_addr"},   32'(rd_addr),   32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"},  32'(out_data),  32'd0);
    chk({tag, "_out_last"},  32'(out_last),  32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
`ifdef SYS_OUT_RD_PARITY_EN
    chk({tag, "_out_par"},   32'(out_par),   32'd0);
`endif
  endtask

  // mode 0: always ready; 1: ready pattern 1,0,0,1; 2: stall cycles 11..15
  function automatic logic ready_for(input int mode, input int c);
    if (mode == 1) return ((c % 4) == 0) || ((c % 4) == 3);
    if (mode == 2) return !((c >= 11) && (c <= 15));
    return 1'b1;
  endfunction

  // One full pass started in relative cycle 0, checked word by word.
  task automatic run_pass(input int mode, input int second_at, input bit start_on_done);
    int c;
    int ndone;
    int done_c;
    int post;
    q_data.delete(); q_last.delete(); q_cyc.delete(); q_par.delete();
    ndone  = 0;
    done_c = -1;
    post   = 0;
    pass_s = cyc;
    for (int n = 0; n < 400 && post < 6; n++) begin
      c         = cyc - pass_s;
      start     = (c == 0) || (c == second_at);
      out_ready = ready_for(mode, c);
      #1;
      if (c == 0) chk("busy_c0", 32'(busy), 32'd0);
      if (c == 1) begin
        chk("busy_c1", 32'(busy), 32'd1);
        chk("rd_en_c1", 32'(rd_en), 32'd1);
        chk("rd_addr_c1", 32'(rd_addr), 32'd0);
      end
      if (mode == 2 && c >= 11 && c <= 15) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(ram[8]));
        chk("stall_last", 32'(out_last), 32'd1);
      end
      if (done_c >= 0) begin
        post++;
        chk("busy_after", 32'(busy), 32'd0);
        chk("rd_en_after", 32'(rd_en), 32'd0);
      end
      if (done) begin
        ndone++;
        if (done_c < 0) begin
          done_c = c;
          chk("busy_at_done", 32'(busy), 32'd0);
          if (start_on_done) start = 1'b1;
        end
      end
      tick();
    end
    start = 1'b0;
    if (done_c < 0) chk("timeout", 32'd0, 32'd1);
    if (mode == 0) chk("done_cycle", 32'(done_c), 32'd30);
    chk("done_pulses", 32'(ndone), 32'd1);
    chk("word_count", 32'(q_data.size()), 32'(NW));
    for (int k = 1; k <= NW && k <= q_data.size(); k++) begin
      chk("word_data", 32'(q_data[k-1]), 32'(ram[(k-1) % M]));
      chk("word_last", 32'(q_last[k-1]), 32'((k % M) == 0));
      if (mode == 0) chk("word_cycle", 32'(q_cyc[k-1]), 32'(k + 2));
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 16'h0100 + 16'(i);
    reset_n = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("por");
    reset_n = 1'b1;
    repeat (2) tick();

    // Free run, then a start during the done cycle which must be dropped
    run_pass(0, -1, 1'b1);
    repeat (2) tick();

    // Periodic backpressure
    run_pass(1, -1, 1'b0);
    repeat (2) tick();

    // Stall on the frame-final word
    run_pass(2, -1, 1'b0);
    repeat (2) tick();

    // Second start while busy
    run_pass(0, 10, 1'b0);
    repeat (2) tick();

    // Reset in the middle of a pass
    pass_s = cyc;
    for (int n = 0; n < 15; n++) begin
      start     = (n == 0);
      out_ready = 1'b1;
      tick();
    end
    start   = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("mid");
    repeat (2) tick();
    chk_reset_outputs("held");
    reset_n = 1'b1;
    repeat (2) tick();
    run_pass(0, -1, 1'b0);
    repeat (2) tick();

`ifdef SYS_OUT_RD_PARITY_EN
    ram[1] = 16'h0001;
    ram[8] = 16'h0003;
    run_pass(0, -1, 1'b0);
    if (q_par.size() >= M) begin
      chk("par_0001_last0", 32'(q_par[1]), 32'd1);
      chk("par_0003_last1", 32'(q_par[8]), 32'd1);
    end else begin
      chk("par_words", 32'(q_par.size()), 32'(M));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want test end");
    $fatal(1, "watchdog expired");
  end

endmodule
